// File: rtl/mac_tx_pkg.sv
`default_nettype none
// ============================================================
// mac_tx_pkg : shared types, K-symbol codes and lane helper
// Rev 1.0
// ============================================================
package mac_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STP_S  = 3'd1,
        DATA   = 3'd2,
        END_ST = 3'd3,
        PAD_ST = 3'd4,
        SKP_OS = 3'd5
    } tx_state_e;

    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_PAD = 8'hF7;
    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_SKP = 8'h1C;

    // Unsupported bus widths fall back to a single lane.
    function automatic logic [2:0] lanes(input logic [5:0] width);
        case (width)
            6'd16:   lanes = 3'd2;
            6'd32:   lanes = 3'd4;
            default: lanes = 3'd1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_tx_framer_packer.sv
`default_nettype none
// ============================================================
// tx_symbol_packer : gathers symbols into 1/2/4-lane words
// Rev 1.0
// ============================================================
module tx_symbol_packer
    import mac_tx_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [2:0]  num_lanes,
    input  logic        push,
    input  logic [7:0]  sym_data,
    input  logic        sym_k,
    output logic [31:0] word_data,
    output logic [3:0]  word_k,
    output logic        word_en,
    output logic        empty,
    output logic        last_slot
);

    logic [31:0] acc_data;
    logic [3:0]  acc_k;
    logic [2:0]  count;
    logic [31:0] nxt_data;
    logic [3:0]  nxt_k;

    always_comb begin
        nxt_data = acc_data;
        nxt_k    = acc_k;
        nxt_data[{count[1:0], 3'b000} +: 8] = sym_data;
        nxt_k[count[1:0]]                   = sym_k;
    end

    // The symbol being pushed now completes the current word.
    assign last_slot = (count == (num_lanes - 3'd1));
    assign empty     = (count == 3'd0);

    always_ff @(posedge clk) begin
        if (clr) begin
            acc_data  <= '0;
            acc_k     <= '0;
            count     <= '0;
            word_data <= '0;
            word_k    <= '0;
            word_en   <= 1'b0;
        end else begin
            word_en <= 1'b0;
            if (push) begin
                if (last_slot) begin
                    // Accumulator is zeroed so lanes above N stay 0 next word.
                    word_data <= nxt_data;
                    word_k    <= nxt_k;
                    word_en   <= 1'b1;
                    acc_data  <= '0;
                    acc_k     <= '0;
                    count     <= '0;
                end else begin
                    acc_data <= nxt_data;
                    acc_k    <= nxt_k;
                    count    <= count + 3'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mac_tx_framer.sv
`default_nettype none
// ============================================================
// mac_tx_framer : byte stream to STP/END/PAD framed TX words
// Rev 1.0
// ============================================================
module mac_tx_framer
    import mac_tx_pkg::*;
#(
    parameter int         SKP_INTERVAL = 1180,
    parameter logic [7:0] STP          = K_STP,
    parameter logic [7:0] END_S        = K_END,
    parameter logic [7:0] PAD          = K_PAD,
    parameter logic [7:0] COM          = K_COM,
    parameter logic [7:0] SKP          = K_SKP
) (
    input  logic        PCLK,
    input  logic        Reset_n,
    input  logic [5:0]  DataBusWidth,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic [31:0] MAC_TX_Data,
    output logic [3:0]  MAC_TX_DataK,
    output logic        MAC_Data_En,
    output logic        busy
);

    localparam int CNT_W = $clog2(SKP_INTERVAL);

    tx_state_e        state;
    tx_state_e        state_nxt;
    logic [2:0]       num_lanes;
    logic [CNT_W-1:0] skp_cnt;
    logic             skp_due;
    logic             skp_expire;
    logic [1:0]       skp_idx;
    logic             push;
    logic [7:0]       sym_data;
    logic             sym_k;
    logic             pk_empty;
    logic             pk_last;

    assign skp_expire = (skp_cnt == CNT_W'(SKP_INTERVAL - 1));

    always_ff @(posedge PCLK) begin
        if (!Reset_n) begin
            state     <= IDLE;
            num_lanes <= 3'd1;
            skp_cnt   <= '0;
            skp_due   <= 1'b0;
            skp_idx   <= 2'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pk_empty)
                num_lanes <= lanes(DataBusWidth);
            skp_cnt <= skp_expire ? '0 : skp_cnt + CNT_W'(1);
            // A request pending at SKP_OS entry is consumed; a coincident expiry is absorbed.
            if (state == IDLE && skp_due)
                skp_due <= 1'b0;
            else if (skp_expire)
                skp_due <= 1'b1;
            skp_idx <= (state == SKP_OS) ? skp_idx + 2'd1 : 2'd0;
        end
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        sym_data  = 8'h00;
        sym_k     = 1'b0;
        s_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (skp_due)
                    state_nxt = SKP_OS;
                else if (s_valid)
                    state_nxt = STP_S;
            end
            STP_S: begin
                push      = 1'b1;
                sym_data  = STP;
                sym_k     = 1'b1;
                state_nxt = DATA;
            end
            DATA: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    push     = 1'b1;
                    sym_data = s_data;
                    if (s_last)
                        state_nxt = END_ST;
                end
            end
            END_ST: begin
                push      = 1'b1;
                sym_data  = END_S;
                sym_k     = 1'b1;
                state_nxt = pk_last ? IDLE : PAD_ST;
            end
            PAD_ST: begin
                push     = 1'b1;
                sym_data = PAD;
                sym_k    = 1'b1;
                if (pk_last)
                    state_nxt = IDLE;
            end
            SKP_OS: begin
                push     = 1'b1;
                sym_data = (skp_idx == 2'd0) ? COM : SKP;
                sym_k    = 1'b1;
                if (skp_idx == 2'd3)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    tx_symbol_packer u_packer (
        .clk       (PCLK),
        .clr       (!Reset_n),
        .num_lanes (num_lanes),
        .push      (push),
        .sym_data  (sym_data),
        .sym_k     (sym_k),
        .word_data (MAC_TX_Data),
        .word_k    (MAC_TX_DataK),
        .word_en   (MAC_Data_En),
        .empty     (pk_empty),
        .last_slot (pk_last)
    );

    assign busy = (state != IDLE) || !pk_empty;

endmodule
`default_nettype wire
